// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_pkg
// Brief   : Shared widths and FSM encoding for the serial system bus ports.
// Revision: 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int c_ADDR_WIDTH = 12;
    localparam int c_DATA_WIDTH = 8;

    localparam int c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE     = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_WAIT_RDY = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_SHIFT    = 2'd2;
    localparam logic [c_STATE_W-1:0] c_ST_DONE     = 2'd3;

    // A one-bit address still needs a one-bit counter.
    function automatic int bit_cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int c_BIT_CNT_W = bit_cnt_width(c_ADDR_WIDTH);

endpackage
`default_nettype wire

// File: rtl/master_out_port_if.sv
`default_nettype none
// ============================================================================
// Module  : master_out_port_if
// Brief   : Request and serial-line bundle between master core, port and slave.
// Revision: 1.0 - initial release
// ============================================================================
interface master_out_port_if #(
    parameter int ADDR_WIDTH = bus_pkg::c_ADDR_WIDTH,
    parameter int DATA_WIDTH = bus_pkg::c_DATA_WIDTH
);
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_address;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  req_ready;
    logic                  slave_ready;
    logic                  master_valid;
    logic                  tx_address;
    logic                  tx_data;
    logic                  busy;
    logic                  tx_done;

    modport master (
        input  req_valid, req_address, req_data, slave_ready,
        output req_ready, master_valid, tx_address, tx_data, busy, tx_done
    );

    modport slave (
        output req_valid, req_address, req_data, slave_ready,
        input  req_ready, master_valid, tx_address, tx_data, busy, tx_done
    );
endinterface
`default_nettype wire

// File: rtl/master_out_port_piso_shift_reg.sv
`default_nettype none
// ============================================================================
// Module  : piso_shift_reg
// Brief   : Parallel-load, shift-right register presenting its LSB serially.
// Revision: 1.0 - initial release
// ============================================================================
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_load,
    input  wire logic             i_shift_en,
    input  wire logic [WIDTH-1:0] i_load_value,
    output logic                  o_serial_out
);
    logic [WIDTH-1:0] r_sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_load_value;
        end else if (i_shift_en) begin
            r_sr <= r_sr >> 1;
        end
    end

    assign o_serial_out = r_sr[0];
endmodule
`default_nettype wire

// File: rtl/master_out_port.sv
`default_nettype none
// ============================================================================
// Module  : master_out_port
// Brief   : Serial bus transmit port; sends address and data LSB-first after a
//           valid/ready handshake. MASTER_OUT_REQ_BUF_EN adds a request buffer.
// Revision: 1.0 - initial release
// ============================================================================
module master_out_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH
) (
    input  wire logic          clk,
    input  wire logic          reset,
    master_out_port_if.master  bus
);
    localparam int                 c_CNT_W     = bit_cnt_width(ADDR_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST_ADDR = c_CNT_W'(ADDR_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_DATA = c_CNT_W'(DATA_WIDTH - 1);

    logic [c_STATE_W-1:0]  r_state;
    logic [c_STATE_W-1:0]  w_next_state;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic                  r_master_valid;
    logic                  r_tx_address;
    logic                  r_tx_data;
    logic                  r_tx_done;
    logic                  r_busy;

    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_start;
    logic                  w_handshake;
    logic                  w_shift;
    logic                  w_last_bit;
    logic [ADDR_WIDTH-1:0] w_load_addr;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic                  w_addr_bit;
    logic                  w_data_bit;

    assign w_accept    = bus.req_valid & w_req_ready;
    assign w_handshake = (r_state == c_ST_WAIT_RDY) & r_master_valid & bus.slave_ready;
    assign w_last_bit  = (r_state == c_ST_SHIFT) & (r_bit_cnt == c_LAST_ADDR);
    assign w_shift     = w_handshake | (r_state == c_ST_SHIFT);

`ifdef MASTER_OUT_REQ_BUF_EN
    logic                  r_buf_full;
    logic [ADDR_WIDTH-1:0] r_buf_addr;
    logic [DATA_WIDTH-1:0] r_buf_data;
    logic                  w_can_start;

    // A buffered request always goes out before a freshly presented one.
    assign w_can_start = (r_state == c_ST_IDLE) | (r_state == c_ST_DONE);
    assign w_req_ready = ~r_buf_full;
    assign w_start     = w_can_start & (r_buf_full | w_accept);
    assign w_load_addr = r_buf_full ? r_buf_addr : bus.req_address;
    assign w_load_data = r_buf_full ? r_buf_data : bus.req_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf_full <= 1'b0;
            r_buf_addr <= '0;
            r_buf_data <= '0;
        end else if (w_accept & ~w_can_start) begin
            r_buf_full <= 1'b1;
            r_buf_addr <= bus.req_address;
            r_buf_data <= bus.req_data;
        end else if (w_can_start & r_buf_full) begin
            r_buf_full <= 1'b0;
        end
    end
`else
    assign w_req_ready = (r_state == c_ST_IDLE);
    assign w_start     = (r_state == c_ST_IDLE) & w_accept;
    assign w_load_addr = bus.req_address;
    assign w_load_data = bus.req_data;
`endif

    piso_shift_reg #(.WIDTH(ADDR_WIDTH)) u_addr_sr (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_start),
        .i_shift_en   (w_shift),
        .i_load_value (w_load_addr),
        .o_serial_out (w_addr_bit)
    );

    piso_shift_reg #(.WIDTH(DATA_WIDTH)) u_data_sr (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_start),
        .i_shift_en   (w_shift),
        .i_load_value (w_load_data),
        .o_serial_out (w_data_bit)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:     if (w_start) w_next_state = c_ST_WAIT_RDY;
            c_ST_WAIT_RDY: if (w_handshake) w_next_state = c_ST_SHIFT;
            c_ST_SHIFT:    if (w_last_bit) w_next_state = c_ST_DONE;
            c_ST_DONE:     w_next_state = w_start ? c_ST_WAIT_RDY : c_ST_IDLE;
            default:       w_next_state = c_ST_IDLE;
        endcase
    end

    // The serial lines always show the register LSB that was current one edge
    // earlier, so bit k is on the wire during cycle k+1 after the handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= c_ST_IDLE;
            r_busy         <= 1'b0;
            r_bit_cnt      <= '0;
            r_master_valid <= 1'b0;
            r_tx_address   <= 1'b0;
            r_tx_data      <= 1'b0;
            r_tx_done      <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_busy    <= (w_next_state != c_ST_IDLE);
            r_tx_done <= w_last_bit;

            if (w_start) begin
                r_master_valid <= 1'b1;
            end else if (w_handshake) begin
                r_master_valid <= 1'b0;
            end

            if (w_handshake) begin
                r_bit_cnt    <= '0;
                r_tx_address <= w_addr_bit;
                r_tx_data    <= w_data_bit;
            end else if (r_state == c_ST_SHIFT) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (w_last_bit) begin
                    r_tx_address <= 1'b0;
                    r_tx_data    <= 1'b0;
                end else begin
                    r_tx_address <= w_addr_bit;
                    r_tx_data    <= (r_bit_cnt < c_LAST_DATA) ? w_data_bit : 1'b0;
                end
            end
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.master_valid = r_master_valid;
    assign bus.tx_address   = r_tx_address;
    assign bus.tx_data      = r_tx_data;
    assign bus.busy         = r_busy;
    assign bus.tx_done      = r_tx_done;
endmodule
`default_nettype wire
